// File: rtl/fir_param.sv
// rtl/fir_param.sv - parametrised direct-form FIR, two-stage valid-tagged pipeline, optional FIR_SAT_EN output clamp
module fir_param #(
  parameter int N_TAPS = 11,
  parameter int DIN_W  = 16,
  parameter int COEF_W = 9,
  parameter int DOUT_W = 16,
  localparam int AW    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CLR,
  input  logic signed [DIN_W-1:0]  DIN,
  input  logic                     VIN,
  input  logic                     COEF_WE,
  input  logic [AW-1:0]            COEF_ADDR,
  input  logic signed [COEF_W-1:0] COEF_DIN,
  output logic signed [DOUT_W-1:0] DOUT,
  output logic                     VOUT
);

  localparam int PW    = DIN_W + COEF_W;
  localparam int ACC_W = DIN_W + COEF_W + $clog2(N_TAPS);
  localparam logic [AW:0] N_TAPS_L = (AW + 1)'(N_TAPS);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DOUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  logic signed [DIN_W-1:0]  x  [N_TAPS];
  logic signed [DIN_W-1:0]  xn [N_TAPS];
  logic signed [COEF_W-1:0] b  [N_TAPS];
  logic signed [PW-1:0]     p  [N_TAPS];
  logic                     v1;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DOUT_W-1:0] reduced;

  // Delay line view including the sample arriving this cycle
  always_comb begin
    xn[0] = DIN;
    for (int k = 1; k < N_TAPS; k++) begin
      xn[k] = x[k-1];
    end
  end

  // Delay line: shift on VIN, flushed by CLR (CLR wins, sample dropped)
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < N_TAPS; k++) x[k] <= '0;
    end else if (CLR) begin
      for (int k = 0; k < N_TAPS; k++) x[k] <= '0;
    end else if (VIN) begin
      for (int k = 0; k < N_TAPS; k++) x[k] <= xn[k];
    end
  end

  // Coefficient bank: out-of-range addresses are ignored, CLR does not block writes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < N_TAPS; k++) b[k] <= '0;
    end else if (COEF_WE && ({1'b0, COEF_ADDR} < N_TAPS_L)) begin
      b[COEF_ADDR] <= COEF_DIN;
    end
  end

  // Stage 1: register per-tap products with the pre-write coefficients
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < N_TAPS; k++) p[k] <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= VIN && !CLR;
      if (VIN && !CLR) begin
        for (int k = 0; k < N_TAPS; k++) begin
          p[k] <= PW'(xn[k]) * PW'(b[k]);
        end
      end
    end
  end

  // Stage 2 datapath: full-width sum, Q-scale shift, then clamp or wrap
  always_comb begin
    acc = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      acc = acc + ACC_W'(p[k]);
    end
    shifted = acc >>> (COEF_W - 1);
`ifdef FIR_SAT_EN
    if (shifted > SAT_MAX) begin
      reduced = DOUT_W'(SAT_MAX);
    end else if (shifted < SAT_MIN) begin
      reduced = DOUT_W'(SAT_MIN);
    end else begin
      reduced = DOUT_W'(shifted);
    end
`else
    reduced = DOUT_W'(shifted);
`endif
  end

  // Output register: DOUT only updates on a valid stage-1 result, CLR kills the pending one
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DOUT <= '0;
      VOUT <= 1'b0;
    end else if (CLR) begin
      VOUT <= 1'b0;
    end else if (v1) begin
      DOUT <= reduced;
      VOUT <= 1'b1;
    end else begin
      VOUT <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_param.sv
// tb/tb_fir_param.sv - self-checking bench for fir_param with cycle model and directed vectors
module tb_fir_param;

  localparam int N = 11;

  logic              CLK = 1'b0;
  logic              RST;
  logic              CLR;
  logic signed [15:0] DIN;
  logic              VIN;
  logic              COEF_WE;
  logic [3:0]        COEF_ADDR;
  logic signed [8:0] COEF_DIN;
  logic signed [15:0] DOUT;
  logic              VOUT;

  int errors = 0;
  int checks = 0;

  // model state
  int  hist [N];
  int  coef [N];
  bit  s1_v;
  int  s1_val;
  bit  exp_vout;
  int  exp_dout;
  int  cap [$];

  fir_param dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .DIN(DIN), .VIN(VIN),
    .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR), .COEF_DIN(COEF_DIN),
    .DOUT(DOUT), .VOUT(VOUT)
  );

  always #5 CLK = ~CLK;

  function automatic int reduce(longint sum);
    longint s;
    logic [15:0] lo;
    s = sum >>> 8;
`ifdef FIR_SAT_EN
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return int'(s);
`else
    lo = s[15:0];
    return int'($signed(lo));
`endif
  endfunction

  task automatic check(string name, int actual, int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
    end
  endtask

  // behavioural model: result computed from the filter equation, delivered two edges later
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < N; k++) begin hist[k] = 0; coef[k] = 0; end
      s1_v = 0; s1_val = 0; exp_vout = 0; exp_dout = 0;
    end else begin
      longint sum;
      if (CLR) exp_vout = 0;
      else if (s1_v) begin exp_vout = 1; exp_dout = s1_val; end
      else exp_vout = 0;
      if (CLR) begin
        s1_v = 0;
        for (int k = 0; k < N; k++) hist[k] = 0;
      end else if (VIN) begin
        for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(DIN);
        sum = 0;
        for (int k = 0; k < N; k++) sum += longint'(hist[k]) * longint'(coef[k]);
        s1_v = 1;
        s1_val = reduce(sum);
      end else begin
        s1_v = 0;
      end
      if (COEF_WE && COEF_ADDR < N) coef[COEF_ADDR] = int'(COEF_DIN);
    end
  end

  // compare DUT against model every cycle out of reset; collect delivered samples
  always @(negedge CLK) begin
    if (!RST) begin
      check("vout", int'(VOUT), int'(exp_vout));
      check("dout", int'(DOUT), exp_dout);
      if (VOUT) cap.push_back(int'(DOUT));
    end
  end

  task automatic idle();
    VIN = 0; CLR = 0; COEF_WE = 0; DIN = 0; COEF_ADDR = 0; COEF_DIN = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic wr(int a, int v);
    COEF_WE = 1; COEF_ADDR = 4'(a); COEF_DIN = 9'(v);
    tick();
  endtask

  task automatic smp(int d);
    VIN = 1; DIN = 16'(d);
    tick();
  endtask

  task automatic flush();
    CLR = 1;
    tick();
    repeat (3) tick();
    cap.delete();
  endtask

  initial begin
    RST = 1;
    idle();
    #1;
    check("reset_dout", int'(DOUT), 0);
    check("reset_vout", int'(VOUT), 0);
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    tick();

    // impulse response
    for (int k = 0; k < N; k++) wr(k, k + 1);
    cap.delete();
    smp(256);
    for (int i = 0; i < 10; i++) smp(0);
    repeat (3) tick();
    check("impulse_count", cap.size(), 11);
    for (int i = 0; i < 11 && i < cap.size(); i++) check("impulse_tap", cap[i], i + 1);

    // gaps then CLR
    wr(0, 128);
    for (int k = 1; k < N; k++) wr(k, 0);
    flush();
    for (int i = 0; i < 3; i++) begin smp(1000); tick(); tick(); end
    repeat (2) tick();
    check("gap_count", cap.size(), 3);
    for (int i = 0; i < 3 && i < cap.size(); i++) check("gap_val", cap[i], 500);
    smp(-600);
    CLR = 1;
    tick();
    repeat (4) tick();
    check("clr_dropped", cap.size(), 3);
    check("clr_dout_held", int'(DOUT), 500);

    // positive overflow
    for (int k = 0; k < N; k++) wr(k, 255);
    flush();
    for (int i = 0; i < N; i++) smp(32767);
    repeat (3) tick();
    check("ovf_pos_count", cap.size(), 11);
`ifdef FIR_SAT_EN
    check("ovf_pos_last", cap[$], 32767);
`else
    check("ovf_pos_last", cap[$], 31349);
`endif

    // negative overflow
    flush();
    for (int i = 0; i < N; i++) smp(-32768);
    repeat (3) tick();
    check("ovf_neg_count", cap.size(), 11);
`ifdef FIR_SAT_EN
    check("ovf_neg_last", cap[$], -32768);
`else
    check("ovf_neg_last", cap[$], -31360);
`endif

    // coefficient write collision and out-of-range write
    wr(0, 64);
    for (int k = 1; k < N; k++) wr(k, 0);
    flush();
    VIN = 1; DIN = 400; COEF_WE = 1; COEF_ADDR = 0; COEF_DIN = 128;
    tick();
    smp(400);
    wr(12, 100);
    smp(400);
    repeat (3) tick();
    check("coll_count", cap.size(), 3);
    if (cap.size() == 3) begin
      check("coll_old_coef", cap[0], 100);
      check("coll_new_coef", cap[1], 200);
      check("coll_addr12", cap[2], 200);
    end

    // asynchronous reset mid-stream
    smp(1000);
    smp(1000);
    smp(1000);
    #2 RST = 1;
    #1;
    check("async_rst_dout", int'(DOUT), 0);
    check("async_rst_vout", int'(VOUT), 0);
    @(posedge CLK);
    #1 RST = 0;
    cap.delete();
    smp(1000);
    repeat (3) tick();
    check("post_rst_count", cap.size(), 1);
    if (cap.size() == 1) check("post_rst_dout", cap[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
